// File: rtl/miner_spi_host.sv
// SPI mode-0 host: sends MSG_START plus a 76-byte mining job, then polls the miner status byte.
// Byte period 18*CLK_DIV+GAP clks; start is accepted only in IDLE (ignored while busy or during done).
module miner_spi_host #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned GAP      = 8,
   parameter int unsigned POLL_MAX = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] first_stage_hash,
   input  logic [95:0]  input_M,
   input  logic [255:0] prev_blk,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic         timeout,
   output logic [7:0]   last_status,
   output logic         sck,
   output logic         mosi,
   output logic         ssel,
   input  logic         miso
);

   localparam logic [2:0] S_IDLE = 3'd0, S_CMD = 3'd1, S_DATA = 3'd2, S_POLL = 3'd3, S_FIN = 3'd4;
   localparam logic [2:0] P_IDLE = 3'd0, P_SETUP = 3'd1, P_HIGH = 3'd2, P_LOW = 3'd3,
                          P_TAIL = 3'd4, P_GAP = 3'd5;
   localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_END = 16'(GAP - 1);

   logic [2:0]   state_q, state_d, phase_q, phase_d;
   logic [15:0]  div_q, div_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [6:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]  poll_cnt_q, poll_cnt_d;
   logic [607:0] tx_buf_q, tx_buf_d;
   logic [7:0]   shift_q, shift_d, rx_q, rx_d, last_status_q, last_status_d;
   logic         sck_q, sck_d, ssel_q, ssel_d, mosi_q, mosi_d;
   logic         found_q, found_d, timeout_q, timeout_d;
   logic [7:0]   tx_byte;
   logic         in_job, div_end, byte_go;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      div_d         = div_q + 16'd1;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      poll_cnt_d    = poll_cnt_q;
      tx_buf_d      = tx_buf_q;
      shift_d       = shift_q;
      rx_d          = rx_q;
      last_status_d = last_status_q;
      sck_d         = sck_q;
      ssel_d        = ssel_q;
      mosi_d        = mosi_q;
      found_d       = found_q;
      timeout_d     = timeout_q;

      case (state_q)
         S_CMD:   tx_byte = 8'hA2;
         S_DATA:  tx_byte = tx_buf_q[607:600];
         default: tx_byte = 8'h00;
      endcase
      in_job  = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_POLL);
      div_end = (div_q == DIV_END);
      byte_go = in_job && ((phase_q == P_IDLE) || ((phase_q == P_GAP) && (div_q == GAP_END)));

      case (state_q)
         S_IDLE: if (start) begin
            tx_buf_d   = {first_stage_hash, input_M, prev_blk};
            found_d    = 1'b0;
            timeout_d  = 1'b0;
            byte_cnt_d = 7'd0;
            poll_cnt_d = 32'd0;
            state_d    = S_CMD;
         end
         S_FIN:   state_d = S_IDLE;
         default: ;
      endcase

      case (phase_q)
         P_IDLE: div_d = 16'd0;
         P_SETUP: if (div_end) begin
            sck_d     = 1'b1;
            rx_d      = {rx_q[6:0], miso};
            bit_cnt_d = 3'd0;
            phase_d   = P_HIGH;
            div_d     = 16'd0;
         end
         P_HIGH: if (div_end) begin
            sck_d   = 1'b0;
            mosi_d  = shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
            phase_d = P_LOW;
            div_d   = 16'd0;
         end
         P_LOW: if (div_end) begin
            div_d = 16'd0;
            if (bit_cnt_q == 3'd7) begin
               phase_d = P_TAIL;
            end else begin
               sck_d     = 1'b1;
               rx_d      = {rx_q[6:0], miso};
               bit_cnt_d = bit_cnt_q + 3'd1;
               phase_d   = P_HIGH;
            end
         end
         P_TAIL: if (div_end) begin
            ssel_d        = 1'b1;
            last_status_d = rx_q;
            div_d         = 16'd0;
            phase_d       = P_GAP;
            case (state_q)
               S_CMD: begin
                  state_d    = S_DATA;
                  byte_cnt_d = 7'd0;
               end
               S_DATA: begin
                  tx_buf_d = {tx_buf_q[599:0], 8'h00};
                  if (byte_cnt_q == 7'd75) begin
                     state_d    = S_POLL;
                     poll_cnt_d = 32'd0;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 7'd1;
                  end
               end
               S_POLL: begin
                  // Unknown or "working" status bytes fall through to another poll.
                  if (rx_q == 8'h06) begin
                     found_d = 1'b1;
                     state_d = S_FIN;
                     phase_d = P_IDLE;
                  end else if (rx_q == 8'hA5) begin
                     state_d = S_FIN;
                     phase_d = P_IDLE;
                  end else if (poll_cnt_q >= POLL_MAX) begin
                     timeout_d = 1'b1;
                     state_d   = S_FIN;
                     phase_d   = P_IDLE;
                  end
               end
               default: ;
            endcase
         end
         P_GAP:   ;
         default: phase_d = P_IDLE;
      endcase

      if (byte_go) begin
         ssel_d  = 1'b0;
         mosi_d  = tx_byte[7];
         shift_d = tx_byte;
         phase_d = P_SETUP;
         div_d   = 16'd0;
         if ((state_q == S_POLL) && (poll_cnt_q != 32'hFFFF_FFFF))
            poll_cnt_d = poll_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         phase_q       <= P_IDLE;
         div_q         <= 16'd0;
         bit_cnt_q     <= 3'd0;
         byte_cnt_q    <= 7'd0;
         poll_cnt_q    <= 32'd0;
         tx_buf_q      <= '0;
         shift_q       <= 8'h00;
         rx_q          <= 8'h00;
         last_status_q <= 8'h00;
         sck_q         <= 1'b0;
         ssel_q        <= 1'b1;
         mosi_q        <= 1'b0;
         found_q       <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         div_q         <= div_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         poll_cnt_q    <= poll_cnt_d;
         tx_buf_q      <= tx_buf_d;
         shift_q       <= shift_d;
         rx_q          <= rx_d;
         last_status_q <= last_status_d;
         sck_q         <= sck_d;
         ssel_q        <= ssel_d;
         mosi_q        <= mosi_d;
         found_q       <= found_d;
         timeout_q     <= timeout_d;
      end
   end

   assign busy        = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_POLL);
   assign done        = (state_q == S_FIN);
   assign found       = found_q;
   assign timeout     = timeout_q;
   assign last_status = last_status_q;
   assign sck         = sck_q;
   assign ssel        = ssel_q;
   assign mosi        = mosi_q;

endmodule
